// File: rtl/instr_encoder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : instr_encoder_if
// Description : Operand-bundle handshake and instruction-memory write port
//               shared between a program source and the instruction encoder.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
interface instr_encoder_if #(
  parameter int ADDR_W = 6
);
  // operand bundle, valid/ready handshake
  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op_kind;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [15:0]       imm;
  // registered instruction-memory write port
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  // program source: drives bundles, observes the write port
  modport master (
    output op_valid, op_kind, rs, rt, rd, shamt, funct, imm,
    input  op_ready, im_we, im_addr, im_wdata
  );

  // encoder: consumes bundles, drives the write port
  modport slave (
    input  op_valid, op_kind, rs, rt, rd, shamt, funct, imm,
    output op_ready, im_we, im_addr, im_wdata
  );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : instr_encoder
// Description : Packs an operation class plus operand fields into a 32-bit
//               MIPS instruction word and writes the words sequentially into
//               instruction memory, starting at word 0 after each start.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         start,
  instr_encoder_if.slave    bus,
  output logic [ADDR_W:0]   word_count,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_word_count;
  logic              r_done;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              w_ready;
  logic              w_accept;
  logic [5:0]        w_opc;
  logic [31:0]       w_enc;

  // a start pulse always takes priority over a bundle in the same cycle
  assign w_ready  = (r_state == ST_LOAD) && !start;
  assign w_accept = bus.op_valid && w_ready;

  // operation class to primary opcode
  always_comb begin
    w_opc = 6'b000000;
    case (bus.op_kind)
      3'd0:    w_opc = 6'b000000;  // R
      3'd1:    w_opc = 6'b100011;  // LW
      3'd2:    w_opc = 6'b101011;  // SW
      3'd3:    w_opc = 6'b000100;  // BEQ
      3'd4:    w_opc = 6'b001000;  // ADDI
      3'd5:    w_opc = 6'b001100;  // ANDI
      3'd6:    w_opc = 6'b001101;  // ORI
      3'd7:    w_opc = 6'b001010;  // SLTI
      default: w_opc = 6'b000000;
    endcase
  end

  // field packing; rd/shamt/funct only matter for R, imm only for I-type
  always_comb begin
    w_enc = {w_opc, bus.rs, bus.rt, bus.imm};
    if (bus.op_kind == 3'd0) begin
      w_enc = {6'b000000, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
    end
  end

  // load FSM with registered write port, pointer, count and full flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_word_count <= '0;
      r_done       <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state      <= ST_LOAD;
            r_wr_ptr     <= '0;
            r_word_count <= '0;
          end
        end
        ST_LOAD: begin
          if (start) begin
            r_state      <= ST_LOAD;
            r_wr_ptr     <= '0;
            r_word_count <= '0;
          end else if (w_accept) begin
            r_we         <= 1'b1;
            r_addr       <= r_wr_ptr;
            r_wdata      <= w_enc;
            r_wr_ptr     <= r_wr_ptr + 1'b1;
            r_word_count <= r_word_count + 1'b1;
            // the final write and the full flag appear in the same cycle
            if (r_wr_ptr == c_last_addr) begin
              r_state <= ST_FULL;
              r_done  <= 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (start) begin
            r_state      <= ST_LOAD;
            r_wr_ptr     <= '0;
            r_word_count <= '0;
            r_done       <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.op_ready = w_ready;
  assign bus.im_we    = r_we;
  assign bus.im_addr  = r_addr;
  assign bus.im_wdata = r_wdata;
  assign word_count   = r_word_count;
  assign done         = r_done;

endmodule
`default_nettype wire
